// File: rtl/down_counter_ctrl_if.sv
// Handshake/control bundle for down_counter_ctrl: start/load/pause/abort in,
// registered count and FSM status out.
interface down_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, load_val, pause, abort,
        input  q, busy, done, state
    );

    modport slave (
        input  start, load_val, pause, abort,
        output q, busy, done, state
    );
endinterface

// File: rtl/down_counter_ctrl.sv
// Start/pause/abort sequencer around a WIDTH-bit down counter with a one-cycle done pulse.
// Optional periodic reload when DOWN_COUNTER_CTRL_AUTO_RELOAD_EN is defined.
module down_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    down_counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_next;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
            reload_reg <= reload_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        reload_next = reload_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    q_next = bus.load_val;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
                    // A zero load also clears the reload value so DONE falls back to IDLE.
                    reload_next = bus.load_val;
`endif
                    state_next = (bus.load_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    q_next     = '0;
                    state_next = IDLE;
                end else if (bus.pause) begin
                    state_next = HOLD;
                end else begin
                    if (q_reg != '0) begin
                        q_next = q_reg - WIDTH'(1);
                    end
                    if (q_reg <= WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    q_next     = '0;
                    state_next = IDLE;
                end else if (!bus.pause) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                q_next     = '0;
                state_next = IDLE;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
                if (!bus.abort && reload_reg != '0) begin
                    q_next     = reload_reg;
                    state_next = RUN;
                end
`endif
            end
            default: begin
                q_next     = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Status is decoded purely from registered state: no input reaches an output combinationally.
    assign bus.q     = q_reg;
    assign bus.state = state_reg;
    assign bus.busy  = (state_reg == RUN) || (state_reg == HOLD);
    assign bus.done  = (state_reg == DONE);
endmodule
